fft_mem_8x8: RTL and testbench
==============================

Name: fft_mem_8x8

Overview:
- 64-entry complex sample store organised as an 8x8 array; it is the responder on the memory interface driven by the 64-point FFT controller.
- Serial 1x1 port: bit-reversed sample load, and natural-order result unload.
- Wide 1x8 port: reads or writes 8 samples per cycle, either along a column (stage 1) or along a row (stage 2), chosen by mem_dim_sel.
- Registered read path, fixed 1-cycle latency, valid echoed alongside data.

Parameters:
- FFT_DAT_WD, 10: width of each real/imag component.
- SIZE_FFT, 64: entry count; fixed 8x8, other values unsupported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- mem_dim_sel  in  1  1x8 access dimension: 0 = column, 1 = row
- mem_rd_addr_1x8  in  3  1x8 read line index
- mem_rd_vld_1x8_inp  in  1  1x8 read request
- mem_rd_vld_1x8_out  out  1  1x8 read data valid
- mem_rd_dat_1x8  out  FFT_DAT_WD*16  8 lanes; lane j = bits [j*2W +: 2W] = {im, re}
- mem_wr_addr_1x8  in  3  1x8 write line index
- mem_wr_vld_1x8  in  1  1x8 write strobe
- mem_wr_dat_1x8  in  FFT_DAT_WD*16  8 lanes, same packing as read data
- mem_rd_addr_1x1  in  6  entry index
- mem_rd_vld_1x1_inp  in  1  1x1 read request
- mem_rd_vld_1x1_out  out  1  1x1 read data valid
- mem_rd_dat_1x1  out  FFT_DAT_WD*2  {im, re}
- mem_wr_addr_1x1  in  6  entry index
- mem_wr_vld_1x1  in  1  1x1 write strobe
- mem_wr_dat_1x1  in  FFT_DAT_WD*2  {im, re}

Behaviour:
- Storage: 64 flop entries of 2*FFT_DAT_WD bits; entry index e = {row[2:0], col[2:0]}.
- 1x8 lane mapping for line index a:
  - dim_sel = 0: lane j ↔ entry 8*j + a (column a).
  - dim_sel = 1: lane j ↔ entry 8*a + j (row a).
  - mem_dim_sel is sampled in the same cycle as the request, independently for read and for write.
- Reads, 1-cycle latency on both ports:
  - A request at edge N produces data and valid after edge N+1 (read/write ports are independent).
  - mem_rd_vld_*_out = mem_rd_vld_*_inp delayed one cycle.
  - Data registers load only on a request and hold their last value otherwise.
  - Back-to-back requests every cycle are supported; there is no backpressure.
- Writes: take effect at the clock edge of the strobe cycle. All four ports may be active in the same cycle.
- Write-write collision: if a 1x1 write and a 1x8 write hit the same entry in one cycle, the 1x8 write wins. Non-overlapping entries are both written.
- Read-write collision, same entry, same cycle: the read returns the pre-write (old) value. Exception: see Optional Feature.
- Address range: every 6-bit and 3-bit address is legal; there is no wrap or error condition.
- Reset (asynchronous):
  - All 64 entries cleared to 0.
  - mem_rd_vld_1x8_out = 0, mem_rd_vld_1x1_out = 0.
  - mem_rd_dat_1x8 = 0, mem_rd_dat_1x1 = 0.
  - A read in flight when reset asserts is discarded; valid does not appear after reset release.
- No state machine beyond the storage and read pipeline registers; all control is a per-cycle decode.

Optional Feature:
- Macro: FFT_MEM_WR_FWD_EN.
- Defined: write-to-read forwarding. A read colliding with a same-cycle write to the same entry returns the newly written value; this applies per lane on the 1x8 port and across ports.
  - If both writes hit the entry, the forwarded value is the 1x8 write data (consistent with 1x8-wins).
- Undefined: read-before-write (old data), as specified in Behaviour.

Decomposition:
- Shared package fft_pkg:
  - FFT_DAT_WD default
  - entry width constant (2*FFT_DAT_WD)
  - lane count 8
  - DIM_COL = 0, DIM_ROW = 1
  - entry-index function idx(dim, a, j)
- Sub-module: fft_mem_addr_map, combinational; (dim_sel, 3-bit addr) → eight 6-bit entry indices. It is instanced once for the read side and once for the write side.

Test Plan:
- Load and unload: 1x1 write entries 0..63 with re = e, im = 63 - e; then 1x1 read 0..63 back-to-back. Required: vld_out exactly 1 cycle after each request, data {63 - e, e}, 64 contiguous valid cycles.
- Column read: after the load, 1x8 read with dim_sel = 0, addr = 3. Required next cycle: lane j re = 8j + 3, i.e. 3, 11, 19, ... 59.
- Row write/read: 1x8 write with dim_sel = 1, addr = 5, lane j re = 100 + j. Then 1x1 read of entry 42 → re = 102. Then 1x8 read with dim_sel = 0, addr = 2 → lane 5 re = 102, other lanes unchanged.
- Collisions:
  - Same cycle: 1x1 write entry 9 with 7, and 1x8 write dim_sel = 0, addr = 1 (covers entry 9, lane 1) with 55. Entry 9 reads 55.
  - 1x1 read of entry 9 concurrent with a write of 77: returns 55 with the macro undefined, 77 with FFT_MEM_WR_FWD_EN defined.
- Reset mid-read: issue a 1x8 read, assert rst_n low before the next edge. Required: vld_out stays 0 and all data is 0; subsequent reads of any entry return 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 64-point FFT sample store.
// Entry index layout: e = {row[2:0], col[2:0]}.
package fft_pkg;

  localparam int FFT_DAT_WD_DFLT = 10;
  localparam int ENT_WD_DFLT     = 2 * FFT_DAT_WD_DFLT;
  localparam int N_LANE          = 8;
  localparam int N_ENT           = 64;

  typedef enum logic {
    DIM_COL = 1'b0,
    DIM_ROW = 1'b1
  } dim_e;

  // Entry touched by lane j of line a: a row line walks the columns, a column line walks the rows.
  function automatic logic [5:0] idx(logic dim, logic [2:0] a, logic [2:0] j);
    if (dim == DIM_ROW) idx = {a, j};
    else                idx = {j, a};
  endfunction

endpackage

// File: rtl/fft_mem_addr_map.sv
// Line-index to entry-index expansion for the 1x8 port.
// Lane j's 6-bit entry index sits in ent_idx[j*6 +: 6].
module fft_mem_addr_map
  import fft_pkg::*;
(
  input  logic        dim_sel,
  input  logic [2:0]  addr,
  output logic [47:0] ent_idx
);

  // Expand one line index into the eight entries it covers
  always_comb begin
    ent_idx = '0;
    for (int j = 0; j < N_LANE; j++) begin
      ent_idx[j*6 +: 6] = idx(dim_sel, addr, 3'(j));
    end
  end

endmodule

// File: rtl/fft_mem_8x8.sv
// 64-entry complex sample store (8x8) serving the FFT controller.
// Serial 1x1 port for load/unload, wide 1x8 port for column/row access.
// Reads have a fixed one-cycle latency and the data registers hold between requests.
// Build option: define FFT_MEM_WR_FWD_EN to forward same-cycle write data to
// colliding reads; by default such reads return the pre-write value.
module fft_mem_8x8
  import fft_pkg::*;
#(
  parameter int FFT_DAT_WD = FFT_DAT_WD_DFLT,
  parameter int SIZE_FFT   = N_ENT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_dim_sel,
  input  logic [2:0]              mem_rd_addr_1x8,
  input  logic                    mem_rd_vld_1x8_inp,
  output logic                    mem_rd_vld_1x8_out,
  output logic [FFT_DAT_WD*16-1:0] mem_rd_dat_1x8,
  input  logic [2:0]              mem_wr_addr_1x8,
  input  logic                    mem_wr_vld_1x8,
  input  logic [FFT_DAT_WD*16-1:0] mem_wr_dat_1x8,
  input  logic [5:0]              mem_rd_addr_1x1,
  input  logic                    mem_rd_vld_1x1_inp,
  output logic                    mem_rd_vld_1x1_out,
  output logic [FFT_DAT_WD*2-1:0] mem_rd_dat_1x1,
  input  logic [5:0]              mem_wr_addr_1x1,
  input  logic                    mem_wr_vld_1x1,
  input  logic [FFT_DAT_WD*2-1:0] mem_wr_dat_1x1
);

  localparam int EW = 2 * FFT_DAT_WD;

  logic [EW-1:0]   mem_q [SIZE_FFT];
  logic [EW-1:0]   mem_d [SIZE_FFT];
  logic [EW-1:0]   rd_src [SIZE_FFT];
  logic [47:0]     rd_idx;
  logic [47:0]     wr_idx;
  logic            rd_vld_1x8_q, rd_vld_1x8_d;
  logic            rd_vld_1x1_q, rd_vld_1x1_d;
  logic [EW*8-1:0] rd_dat_1x8_q, rd_dat_1x8_d;
  logic [EW-1:0]   rd_dat_1x1_q, rd_dat_1x1_d;

  fft_mem_addr_map u_rd_map (
    .dim_sel (mem_dim_sel),
    .addr    (mem_rd_addr_1x8),
    .ent_idx (rd_idx)
  );

  fft_mem_addr_map u_wr_map (
    .dim_sel (mem_dim_sel),
    .addr    (mem_wr_addr_1x8),
    .ent_idx (wr_idx)
  );

  // Next storage image: 1x1 write first so an overlapping 1x8 lane overrides it
  always_comb begin
    for (int e = 0; e < SIZE_FFT; e++) mem_d[e] = mem_q[e];
    if (mem_wr_vld_1x1) mem_d[mem_wr_addr_1x1] = mem_wr_dat_1x1;
    if (mem_wr_vld_1x8) begin
      for (int j = 0; j < N_LANE; j++) begin
        mem_d[wr_idx[j*6 +: 6]] = mem_wr_dat_1x8[j*EW +: EW];
      end
    end
  end

  // Read source: post-write image when forwarding, otherwise the stored image
  always_comb begin
    for (int e = 0; e < SIZE_FFT; e++) begin
`ifdef FFT_MEM_WR_FWD_EN
      rd_src[e] = mem_d[e];
`else
      rd_src[e] = mem_q[e];
`endif
    end
  end

  // Read pipeline next state: capture on request, hold otherwise
  always_comb begin
    rd_vld_1x8_d = mem_rd_vld_1x8_inp;
    rd_vld_1x1_d = mem_rd_vld_1x1_inp;
    rd_dat_1x8_d = rd_dat_1x8_q;
    rd_dat_1x1_d = rd_dat_1x1_q;
    if (mem_rd_vld_1x1_inp) rd_dat_1x1_d = rd_src[mem_rd_addr_1x1];
    if (mem_rd_vld_1x8_inp) begin
      for (int j = 0; j < N_LANE; j++) begin
        rd_dat_1x8_d[j*EW +: EW] = rd_src[rd_idx[j*6 +: 6]];
      end
    end
  end

  // Storage and read registers; reset clears everything, dropping any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < SIZE_FFT; e++) mem_q[e] <= '0;
      rd_vld_1x8_q <= 1'b0;
      rd_vld_1x1_q <= 1'b0;
      rd_dat_1x8_q <= '0;
      rd_dat_1x1_q <= '0;
    end else begin
      for (int e = 0; e < SIZE_FFT; e++) mem_q[e] <= mem_d[e];
      rd_vld_1x8_q <= rd_vld_1x8_d;
      rd_vld_1x1_q <= rd_vld_1x1_d;
      rd_dat_1x8_q <= rd_dat_1x8_d;
      rd_dat_1x1_q <= rd_dat_1x1_d;
    end
  end

  assign mem_rd_vld_1x8_out = rd_vld_1x8_q;
  assign mem_rd_vld_1x1_out = rd_vld_1x1_q;
  assign mem_rd_dat_1x8     = rd_dat_1x8_q;
  assign mem_rd_dat_1x1     = rd_dat_1x1_q;

endmodule

// File: tb/tb_fft_mem_8x8.sv
// Self-checking bench for fft_mem_8x8: directed sequences, a constant vector
// table and randomized traffic compared against an array-based reference.
module tb_fft_mem_8x8;

  localparam int W  = 10;
  localparam int EW = 20;
  localparam int LW = 160;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_dim_sel = 1'b0;
  logic [2:0]    mem_rd_addr_1x8 = '0;
  logic          mem_rd_vld_1x8_inp = 1'b0;
  logic          mem_rd_vld_1x8_out;
  logic [LW-1:0] mem_rd_dat_1x8;
  logic [2:0]    mem_wr_addr_1x8 = '0;
  logic          mem_wr_vld_1x8 = 1'b0;
  logic [LW-1:0] mem_wr_dat_1x8 = '0;
  logic [5:0]    mem_rd_addr_1x1 = '0;
  logic          mem_rd_vld_1x1_inp = 1'b0;
  logic          mem_rd_vld_1x1_out;
  logic [EW-1:0] mem_rd_dat_1x1;
  logic [5:0]    mem_wr_addr_1x1 = '0;
  logic          mem_wr_vld_1x1 = 1'b0;
  logic [EW-1:0] mem_wr_dat_1x1 = '0;

  always #5 clk = ~clk;

  fft_mem_8x8 #(.FFT_DAT_WD(W), .SIZE_FFT(64)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_dim_sel        (mem_dim_sel),
    .mem_rd_addr_1x8    (mem_rd_addr_1x8),
    .mem_rd_vld_1x8_inp (mem_rd_vld_1x8_inp),
    .mem_rd_vld_1x8_out (mem_rd_vld_1x8_out),
    .mem_rd_dat_1x8     (mem_rd_dat_1x8),
    .mem_wr_addr_1x8    (mem_wr_addr_1x8),
    .mem_wr_vld_1x8     (mem_wr_vld_1x8),
    .mem_wr_dat_1x8     (mem_wr_dat_1x8),
    .mem_rd_addr_1x1    (mem_rd_addr_1x1),
    .mem_rd_vld_1x1_inp (mem_rd_vld_1x1_inp),
    .mem_rd_vld_1x1_out (mem_rd_vld_1x1_out),
    .mem_rd_dat_1x1     (mem_rd_dat_1x1),
    .mem_wr_addr_1x1    (mem_wr_addr_1x1),
    .mem_wr_vld_1x1     (mem_wr_vld_1x1),
    .mem_wr_dat_1x1     (mem_wr_dat_1x1)
  );

  int checks = 0;
  int failures = 0;
  int vld11_cnt = 0;

  logic [EW-1:0] mdl [64];
  logic [LW-1:0] exp_1x8 = '0;
  logic [EW-1:0] exp_1x1 = '0;
  logic          expv_1x8 = 1'b0;
  logic          expv_1x1 = 1'b0;

  typedef struct {
    logic       dim;
    logic [2:0] addr;
    int         lane;
    logic [9:0] re;
    logic [9:0] im;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entry hit by lane j of line a: row line = 8a+j, column line = 8j+a
  function automatic int ent(logic dim, int a, int j);
    return dim ? (8 * a + j) : (8 * j + a);
  endfunction

  task automatic clr_inputs();
    mem_rd_vld_1x8_inp = 1'b0;
    mem_rd_vld_1x1_inp = 1'b0;
    mem_wr_vld_1x8     = 1'b0;
    mem_wr_vld_1x1     = 1'b0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < 64; e++) mdl[e] = '0;
    exp_1x8  = '0;
    exp_1x1  = '0;
    expv_1x8 = 1'b0;
    expv_1x1 = 1'b0;
  endtask

  // One clock: predict from the currently driven inputs, advance, compare all outputs
  task automatic step();
    logic [EW-1:0] nxt [64];
    logic [EW-1:0] src [64];
    for (int e = 0; e < 64; e++) nxt[e] = mdl[e];
    if (mem_wr_vld_1x1) nxt[mem_wr_addr_1x1] = mem_wr_dat_1x1;
    if (mem_wr_vld_1x8)
      for (int j = 0; j < 8; j++)
        nxt[ent(mem_dim_sel, int'(mem_wr_addr_1x8), j)] = mem_wr_dat_1x8[j*EW +: EW];
    for (int e = 0; e < 64; e++) begin
`ifdef FFT_MEM_WR_FWD_EN
      src[e] = nxt[e];
`else
      src[e] = mdl[e];
`endif
    end
    expv_1x1 = mem_rd_vld_1x1_inp;
    expv_1x8 = mem_rd_vld_1x8_inp;
    if (mem_rd_vld_1x1_inp) exp_1x1 = src[mem_rd_addr_1x1];
    if (mem_rd_vld_1x8_inp)
      for (int j = 0; j < 8; j++)
        exp_1x8[j*EW +: EW] = src[ent(mem_dim_sel, int'(mem_rd_addr_1x8), j)];
    for (int e = 0; e < 64; e++) mdl[e] = nxt[e];
    @(posedge clk);
    #1;
    if (mem_rd_vld_1x1_out) vld11_cnt++;
    chk("vld_1x8", LW'(mem_rd_vld_1x8_out), LW'(expv_1x8));
    chk("vld_1x1", LW'(mem_rd_vld_1x1_out), LW'(expv_1x1));
    chk("dat_1x8", mem_rd_dat_1x8, exp_1x8);
    chk("dat_1x1", LW'(mem_rd_dat_1x1), LW'(exp_1x1));
  endtask

  initial begin
    // Expected values for entry e after the load are {im = 63-e, re = e}
    vecs[0] = '{1'b0, 3'd3, 0, 10'd3,  10'd60};
    vecs[1] = '{1'b0, 3'd3, 1, 10'd11, 10'd52};
    vecs[2] = '{1'b0, 3'd3, 7, 10'd59, 10'd4};
    vecs[3] = '{1'b1, 3'd5, 2, 10'd42, 10'd21};
    vecs[4] = '{1'b1, 3'd0, 0, 10'd0,  10'd63};
    vecs[5] = '{1'b1, 3'd7, 7, 10'd63, 10'd0};
    vecs[6] = '{1'b0, 3'd0, 4, 10'd32, 10'd31};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld_1x8", LW'(mem_rd_vld_1x8_out), '0);
    chk("rst_vld_1x1", LW'(mem_rd_vld_1x1_out), '0);
    chk("rst_dat_1x8", mem_rd_dat_1x8, '0);
    chk("rst_dat_1x1", LW'(mem_rd_dat_1x1), '0);
    rst_n = 1'b1;

    // Serial load
    for (int e = 0; e < 64; e++) begin
      mem_wr_vld_1x1  = 1'b1;
      mem_wr_addr_1x1 = 6'(e);
      mem_wr_dat_1x1  = {10'(63 - e), 10'(e)};
      step();
    end
    clr_inputs();

    // Back-to-back serial unload
    vld11_cnt = 0;
    for (int e = 0; e < 64; e++) begin
      mem_rd_vld_1x1_inp = 1'b1;
      mem_rd_addr_1x1    = 6'(e);
      step();
      chk("unload_dat", LW'(mem_rd_dat_1x1), LW'({10'(63 - e), 10'(e)}));
    end
    clr_inputs();
    step();
    chk("unload_vld_cnt", LW'(vld11_cnt), LW'(64));

    // Table of 1x8 reads against fixed lane values
    for (int i = 0; i < 7; i++) begin
      mem_dim_sel        = vecs[i].dim;
      mem_rd_addr_1x8    = vecs[i].addr;
      mem_rd_vld_1x8_inp = 1'b1;
      step();
      chk("tbl_re", LW'(mem_rd_dat_1x8[vecs[i].lane*EW +: W]), LW'(vecs[i].re));
      chk("tbl_im", LW'(mem_rd_dat_1x8[vecs[i].lane*EW + W +: W]), LW'(vecs[i].im));
    end
    clr_inputs();

    // Row write, then read back through both ports
    mem_dim_sel     = 1'b1;
    mem_wr_addr_1x8 = 3'd5;
    mem_wr_vld_1x8  = 1'b1;
    for (int j = 0; j < 8; j++) mem_wr_dat_1x8[j*EW +: EW] = {10'(j), 10'(100 + j)};
    step();
    clr_inputs();
    mem_rd_vld_1x1_inp = 1'b1;
    mem_rd_addr_1x1    = 6'd42;
    step();
    clr_inputs();
    chk("row_wr_e42", LW'(mem_rd_dat_1x1[W-1:0]), LW'(102));
    mem_dim_sel        = 1'b0;
    mem_rd_addr_1x8    = 3'd2;
    mem_rd_vld_1x8_inp = 1'b1;
    step();
    clr_inputs();
    chk("col2_lane5", LW'(mem_rd_dat_1x8[5*EW +: W]), LW'(102));
    chk("col2_lane4", LW'(mem_rd_dat_1x8[4*EW +: EW]), LW'({10'd29, 10'd34}));

    // Write-write collision: 1x8 wins on entry 9
    mem_wr_vld_1x1  = 1'b1;
    mem_wr_addr_1x1 = 6'd9;
    mem_wr_dat_1x1  = {10'd0, 10'd7};
    mem_dim_sel     = 1'b0;
    mem_wr_addr_1x8 = 3'd1;
    mem_wr_vld_1x8  = 1'b1;
    for (int j = 0; j < 8; j++) mem_wr_dat_1x8[j*EW +: EW] = {10'd0, 10'd55};
    step();
    clr_inputs();
    mem_rd_vld_1x1_inp = 1'b1;
    mem_rd_addr_1x1    = 6'd9;
    step();
    clr_inputs();
    chk("ww_collide", LW'(mem_rd_dat_1x1[W-1:0]), LW'(55));

    // Read-write collision on entry 9
    mem_rd_vld_1x1_inp = 1'b1;
    mem_rd_addr_1x1    = 6'd9;
    mem_wr_vld_1x1     = 1'b1;
    mem_wr_addr_1x1    = 6'd9;
    mem_wr_dat_1x1     = {10'd0, 10'd77};
    step();
    clr_inputs();
`ifdef FFT_MEM_WR_FWD_EN
    chk("rw_collide", LW'(mem_rd_dat_1x1[W-1:0]), LW'(77));
`else
    chk("rw_collide", LW'(mem_rd_dat_1x1[W-1:0]), LW'(55));
`endif
    mem_rd_vld_1x1_inp = 1'b1;
    step();
    clr_inputs();
    chk("rw_after", LW'(mem_rd_dat_1x1[W-1:0]), LW'(77));

    // Randomized traffic on all four ports, addresses biased toward collisions
    for (int n = 0; n < 400; n++) begin
      mem_dim_sel        = 1'($urandom_range(0, 1));
      mem_wr_vld_1x1     = 1'($urandom_range(0, 1));
      mem_wr_vld_1x8     = 1'($urandom_range(0, 3) == 0);
      mem_rd_vld_1x1_inp = 1'($urandom_range(0, 1));
      mem_rd_vld_1x8_inp = 1'($urandom_range(0, 1));
      mem_wr_addr_1x1    = 6'($urandom_range(0, 15));
      mem_rd_addr_1x1    = ($urandom_range(0, 1) == 1) ? mem_wr_addr_1x1 : 6'($urandom_range(0, 63));
      mem_wr_addr_1x8    = 3'($urandom_range(0, 7));
      mem_rd_addr_1x8    = ($urandom_range(0, 1) == 1) ? mem_wr_addr_1x8 : 3'($urandom_range(0, 7));
      mem_wr_dat_1x1     = 20'($urandom);
      for (int j = 0; j < 8; j++) mem_wr_dat_1x8[j*EW +: EW] = 20'($urandom);
      step();
    end
    clr_inputs();
    step();

    // Reset while a 1x8 read is in flight
    mem_dim_sel        = 1'b0;
    mem_rd_addr_1x8    = 3'd0;
    mem_rd_vld_1x8_inp = 1'b1;
    mem_rd_vld_1x1_inp = 1'b1;
    mem_rd_addr_1x1    = 6'd9;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_vld_1x8", LW'(mem_rd_vld_1x8_out), '0);
    chk("mid_rst_vld_1x1", LW'(mem_rd_vld_1x1_out), '0);
    chk("mid_rst_dat_1x8", mem_rd_dat_1x8, '0);
    chk("mid_rst_dat_1x1", LW'(mem_rd_dat_1x1), '0);
    clr_inputs();
    rst_n = 1'b1;
    model_reset();
    step();
    mem_rd_vld_1x1_inp = 1'b1;
    mem_rd_addr_1x1    = 6'd42;
    mem_dim_sel        = 1'b1;
    mem_rd_addr_1x8    = 3'd5;
    mem_rd_vld_1x8_inp = 1'b1;
    step();
    clr_inputs();
    chk("post_rst_e42", LW'(mem_rd_dat_1x1), '0);
    chk("post_rst_row5", mem_rd_dat_1x8, '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
